// File: rtl/ps2_mouse_device.sv
// ps2_mouse_device
//   Device side of a PS/2 mouse link. The device generates every bus clock,
//   answers host commands and streams 3-byte movement packets.
// Ports:
//   clk                     system clock
//   rst                     asynchronous reset, active low
//   tick_cycle              one-cycle movement sample strobe
//   up/down/left/right      movement requests
//   ps2_clk_in/ps2_data_in  raw bus line levels (pulled high when idle)
//   ps2_clk_oe/ps2_data_oe  1 = drive line low, 0 = release (open drain)
//   enabled                 stream reporting active
//   last_cmd                last host byte received without error
//   rx_err                  one-cycle pulse on a host frame parity/stop error
module ps2_mouse_device #(
    parameter int          HALF_PER = 2500,
    parameter logic [7:0]  STEP     = 8'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_cycle,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       enabled,
    output logic [7:0] last_cmd,
    output logic       rx_err
);
    localparam int CW = $clog2(2 * HALF_PER + 1);
    localparam logic [CW-1:0] H_END  = CW'(HALF_PER);
    localparam logic [CW-1:0] B_END  = CW'(2 * HALF_PER - 1);
    localparam logic [CW-1:0] SAMPLE = CW'(HALF_PER + HALF_PER / 2);
    // Cycles the released clock needs to show up through the synchronizer
    // before a low level can be blamed on the host.
    localparam logic [CW-1:0] GUARD  = CW'(4);

    typedef enum logic [2:0] {IDLE, TX_BIT, RX_BIT, RX_ACK, INHIBIT} state_t;

    state_t        state_q, state_d;
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic [CW-1:0] cnt_q, cnt_d, idle_cnt_q, idle_cnt_d, rts_cnt_q, rts_cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [10:0]   tx_sh_q, tx_sh_d;
    logic [9:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    mem_q [4];
    logic [7:0]    mem_d [4];
    logic [1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [2:0]    count_q, count_d;
    logic [23:0]   seq_q, seq_d;
    logic [1:0]    seq_cnt_q, seq_cnt_d;
    logic          enabled_q, enabled_d, rx_err_q, rx_err_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;

    logic          bus_idle, rts, push, push_ok, pop, flush;
    logic [7:0]    push_byte, head, x, y;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        seq_cnt_d  = seq_cnt_q;
        enabled_d  = enabled_q;
        last_cmd_d = last_cmd_q;
        rx_err_d   = 1'b0;
        push       = 1'b0;
        push_ok    = 1'b0;
        push_byte  = 8'h00;
        pop        = 1'b0;
        flush      = 1'b0;
        clk_oe_d   = 1'b0;
        data_oe_d  = 1'b0;

        clk_s1_d  = ps2_clk_in;
        clk_s2_d  = clk_s1_q;
        data_s1_d = ps2_data_in;
        data_s2_d = data_s1_q;

        bus_idle = (idle_cnt_q >= H_END);
        rts      = (rts_cnt_q >= H_END);
        head     = mem_q[rd_ptr_q];

        idle_cnt_d = (clk_s2_q && data_s2_q)
                   ? ((idle_cnt_q == H_END) ? H_END : idle_cnt_q + CW'(1)) : '0;
        // Request-to-send is only meaningful while the device is not clocking.
        rts_cnt_d = ((state_q == IDLE || state_q == INHIBIT) && clk_s2_q && !data_s2_q)
                  ? ((rts_cnt_q == H_END) ? H_END : rts_cnt_q + CW'(1)) : '0;

        x = 8'd0;
        if (right && !left) x = STEP;
        else if (left && !right) x = 8'd0 - STEP;
        y = 8'd0;
        if (up && !down) y = STEP;
        else if (down && !up) y = 8'd0 - STEP;

        // Multi-byte responses and packets leave the sequencer one byte per
        // cycle, so they always land in the queue back to back.
        if (seq_cnt_q != 2'd0) begin
            push      = 1'b1;
            push_byte = seq_q[7:0];
            seq_d     = {8'h00, seq_q[23:8]};
            seq_cnt_d = seq_cnt_q - 2'd1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = 4'd0;
                if (rts) begin
                    state_d = RX_BIT;
                end else if (bus_idle && count_q != 3'd0) begin
                    state_d = TX_BIT;
                    tx_sh_d = {1'b1, ~^head, head, 1'b0};
                end else if (tick_cycle && enabled_q && count_q == 3'd0 &&
                             seq_cnt_q == 2'd0 && (x != 8'd0 || y != 8'd0)) begin
                    seq_d     = {y, x, {2'b00, y[7], x[7], 1'b1, 3'b000}};
                    seq_cnt_d = 2'd3;
                end
            end
            TX_BIT: begin
                // Each bit: released half (data set) then driven-low half.
                if (cnt_q >= GUARD && cnt_q < H_END && !clk_s2_q) begin
                    state_d = INHIBIT;
                    cnt_d   = '0;
                end else if (cnt_q == B_END) begin
                    cnt_d = '0;
                    if (idx_q == 4'd10) begin
                        state_d = IDLE;
                        pop     = 1'b1;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        tx_sh_d = {1'b1, tx_sh_q[10:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_BIT: begin
                // Each bit: driven-low half then released half, sampled mid-high.
                if (cnt_q == SAMPLE) rx_sh_d = {data_s2_q, rx_sh_q[9:1]};
                if (cnt_q == B_END) begin
                    cnt_d = '0;
                    if (idx_q == 4'd9) begin
                        state_d = rx_sh_q[9] ? RX_ACK : IDLE;
                        if (rx_sh_q[9] && (^rx_sh_q[8:0])) begin
                            last_cmd_d = rx_sh_q[7:0];
                            seq_d      = {16'h0000, 8'hFA};
                            seq_cnt_d  = 2'd1;
                            case (rx_sh_q[7:0])
                                8'hFF: begin
                                    flush     = 1'b1;
                                    enabled_d = 1'b0;
                                    seq_d     = {8'h00, 8'hAA, 8'hFA};
                                    seq_cnt_d = 2'd3;
                                end
                                8'hF4:   enabled_d = 1'b1;
                                8'hF5:   enabled_d = 1'b0;
                                default: ;
                            endcase
                        end else begin
                            rx_err_d  = 1'b1;
                            seq_d     = {16'h0000, 8'hFE};
                            seq_cnt_d = 2'd1;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_ACK: begin
                if (cnt_q == B_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            INHIBIT: begin
                cnt_d = '0;
                idx_d = 4'd0;
                if (rts) state_d = RX_BIT;
                else if (bus_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Aborted TX never pops, so the byte stays at the head for the retry.
        if (flush) begin
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            count_d  = 3'd0;
        end else begin
            push_ok = push && (count_q != 3'd4);
            if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_byte;
                wr_ptr_d        = wr_ptr_q + 2'd1;
            end
            count_d = count_q + 3'(push_ok) - 3'(pop);
        end

        case (state_d)
            TX_BIT: begin
                clk_oe_d  = (cnt_d >= H_END);
                data_oe_d = !tx_sh_d[0];
            end
            RX_BIT: clk_oe_d = (cnt_d < H_END);
            RX_ACK: begin
                clk_oe_d  = (cnt_d < H_END);
                data_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
            rts_cnt_q  <= '0;
            idx_q      <= 4'd0;
            tx_sh_q    <= '1;
            rx_sh_q    <= '0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            // Power-on self-test result is queued as soon as reset lifts.
            seq_q      <= {8'h00, 8'h00, 8'hAA};
            seq_cnt_q  <= 2'd2;
            enabled_q  <= 1'b0;
            last_cmd_q <= 8'h00;
            rx_err_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            data_s1_q  <= data_s1_d;
            data_s2_q  <= data_s2_d;
            cnt_q      <= cnt_d;
            idle_cnt_q <= idle_cnt_d;
            rts_cnt_q  <= rts_cnt_d;
            idx_q      <= idx_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            seq_cnt_q  <= seq_cnt_d;
            enabled_q  <= enabled_d;
            last_cmd_q <= last_cmd_d;
            rx_err_q   <= rx_err_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign enabled     = enabled_q;
    assign last_cmd    = last_cmd_q;
    assign rx_err      = rx_err_q;
endmodule

// File: doc/ps2_mouse_device.md
PS2_MOUSE_DEVICE -- requirements
Module: ps2_mouse_device

Interface
REQ-001 The block SHALL have parameter HALF_PER, default 2500, meaning clk cycles per PS/2 clock half-period (10 kHz at 50 MHz).
REQ-002 The block SHALL have parameter STEP, default 8'd1, meaning the movement magnitude reported per tick per axis.
REQ-003 The block SHALL have port clk, input, 1, the single system clock.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port tick_cycle, input, 1, a one-cycle movement sample strobe.
REQ-006 The block SHALL have ports up, down, left, right, input, 1 each, the movement requests.
REQ-007 The block SHALL have ports ps2_clk_in and ps2_data_in, input, 1 each, the sampled bus lines (pulled high when idle).
REQ-008 The block SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each, where 1 drives the line low and 0 releases it (open-drain).
REQ-009 The block SHALL have port enabled, output, 1, meaning stream reporting is active.
REQ-010 The block SHALL have port last_cmd, output, 8, the last host byte received without error.
REQ-011 The block SHALL have port rx_err, output, 1, a one-cycle pulse on host-frame parity or stop error.

Function
REQ-012 ps2_clk_in and ps2_data_in SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The device SHALL generate every bus clock itself: low for HALF_PER cycles, then released for HALF_PER cycles, per bit.
REQ-014 A TX frame SHALL be 11 bits: start 0, data LSB first, odd parity, stop 1; each bit is set while clk is released and held through the following low phase.
REQ-015 TX SHALL start only when the bus is idle (both lines high for at least HALF_PER cycles) and the TX queue is non-empty.
REQ-016 If the host holds clk low while the device releases it (inhibit), any TX in progress SHALL abort, the byte SHALL remain at the queue head, and TX SHALL restart from the start bit after the bus is idle again.
REQ-017 Host request-to-send SHALL be detected as data low while clk is high for at least HALF_PER cycles; RX then has priority over pending TX.
REQ-018 During RX the device SHALL generate clocks and sample data HALF_PER/2 cycles after each clk release, in this order: 8 data bits LSB first, parity, stop.
REQ-019 After sampling stop = 1, the device SHALL drive data low for one full clock (ack bit) and then release both lines.
REQ-020 The FSM states SHALL be IDLE, TX_BIT, RX_BIT, RX_ACK, INHIBIT, with transitions as defined in REQ-015 to REQ-019.
REQ-021 The TX queue SHALL be a 4-entry byte FIFO; a push to a full queue SHALL be dropped.
REQ-022 On a good RX byte the device SHALL update last_cmd and queue its response:
- FF: flush queue, clear enabled, push FA, AA, 00.
- F4: set enabled, push FA.
- F5: clear enabled, push FA.
- any other byte: push FA.
REQ-023 On a bad RX frame (parity or stop error) the device SHALL pulse rx_err, push FE, and leave last_cmd unchanged.
REQ-024 A tick_cycle pulse SHALL queue a 3-byte packet only if enabled=1, the queue is empty, and the FSM is IDLE; otherwise the tick is dropped.
REQ-025 Packet X SHALL be +STEP for right only, -STEP for left only, and 0 for neither or both; Y SHALL be +STEP for up only, -STEP for down only, and 0 for neither or both; a tick with X=Y=0 SHALL queue nothing.
REQ-026 Packet byte 1 SHALL be {2'b00, Ysign, Xsign, 1'b1, 3'b000}; byte 2 SHALL be X and byte 3 SHALL be Y, both two's complement.
REQ-027 The three packet bytes SHALL be pushed in consecutive cycles and SHALL never interleave with command responses.

Reset
REQ-028 While rst=0, outputs SHALL be: ps2_clk_oe=0, ps2_data_oe=0, enabled=0, last_cmd=8'h00, rx_err=0; the queue SHALL be empty and the FSM in IDLE.
REQ-029 On rst release the device SHALL push AA, 00 (power-on self-test), and the first start bit SHALL follow no earlier than HALF_PER cycles of idle bus.
REQ-030 Reset asserted mid-frame SHALL immediately release both lines and discard all bytes, including any partially sent byte.

Verification
REQ-031 The bench SHALL check reset release with an idle host -> frames AA then 00 are observed with odd parity and stop=1, and enabled=0.
REQ-032 The bench SHALL check that host sends F4 -> the ack bit is driven low, last_cmd=F4, enabled=1, and FA is transmitted.
REQ-033 The bench SHALL check that enabled=1, right=1, up=1, and a tick_cycle pulse -> bytes 08, 01, 01 are transmitted; with left=1 and down=1 instead -> 38, FF, FF.
REQ-034 The bench SHALL check that host sends 5A with wrong parity -> rx_err pulses once, FE is transmitted, and last_cmd is unchanged.
REQ-035 The bench SHALL check that host inhibits clk during bit 4 of FA -> TX aborts and the full FA frame is resent after idle.
REQ-036 The bench SHALL check that host sends FF while the packet queue is non-empty -> the queue is flushed, FA, AA, 00 are transmitted, and enabled=0.
